// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and the beam coordinate type.
// Shared by the raster generator and its axis counters.
package vga_timing_pkg;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_TOP     = 33;
  localparam int unsigned DEF_V_BOTTOM  = 10;
  localparam int unsigned DEF_V_SYNC    = 2;

  localparam int unsigned DEF_H_TOTAL =
    DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL =
    DEF_V_DISPLAY + DEF_V_BOTTOM + DEF_V_SYNC + DEF_V_TOP;

  localparam int unsigned DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int unsigned DEF_H_SYNC_END   =
    DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_BOTTOM;
  localparam int unsigned DEF_V_SYNC_END   =
    DEF_V_SYNC_START + DEF_V_SYNC - 1;

  localparam int unsigned COORD_LIMIT = 1024;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL beam axis counter with count enable.
// o_nxt is the value the counter takes on the next edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL = DEF_H_TOTAL
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_en,
  output coord_t o_cnt,
  output coord_t o_nxt,
  output logic   o_wrap
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  coord_t r_cnt;
  coord_t w_nxt;
  logic   w_last;

  assign w_last = (r_cnt == LAST);

  // next count: hold when idle, wrap at the last position
  always_comb begin
    w_nxt = r_cnt;
    if (i_en) begin
      w_nxt = w_last ? '0 : r_cnt + coord_t'(1);
    end
  end

  // counter register, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_nxt  = w_nxt;
  assign o_wrap = i_en && w_last;

endmodule

// File: rtl/vga_hvsync_gen.sv
// VGA raster timing: beam position, syncs and display qualifier.
// Define HVSYNC_FRAME_PULSE_EN to add the frame_start output.
module vga_hvsync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_TOP     = DEF_V_TOP,
  parameter int unsigned V_BOTTOM  = DEF_V_BOTTOM,
  parameter int unsigned V_SYNC    = DEF_V_SYNC
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef HVSYNC_FRAME_PULSE_EN
  output logic       frame_start,
`endif
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);

  localparam int unsigned H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL =
    V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_BOTTOM;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam coord_t HS_LO = coord_t'(H_SYNC_START);
  localparam coord_t HS_HI = coord_t'(H_SYNC_END);
  localparam coord_t VS_LO = coord_t'(V_SYNC_START);
  localparam coord_t VS_HI = coord_t'(V_SYNC_END);
  localparam coord_t H_VIS = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS = coord_t'(V_DISPLAY);

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
    $error("vga_hvsync_gen: H_TOTAL/V_TOTAL exceed 1024");
  end

  coord_t w_hcnt;
  coord_t w_hnxt;
  coord_t w_vcnt;
  coord_t w_vnxt;
  logic   w_hwrap;
  logic   w_vwrap;

  logic   r_hsync;
  logic   r_vsync;
  logic   r_de;

  vga_axis_counter #(
    .TOTAL (H_TOTAL)
  ) u_hcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (1'b1),
    .o_cnt  (w_hcnt),
    .o_nxt  (w_hnxt),
    .o_wrap (w_hwrap)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL)
  ) u_vcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_hwrap),
    .o_cnt  (w_vcnt),
    .o_nxt  (w_vnxt),
    .o_wrap (w_vwrap)
  );

  // decode syncs/qualifier from next counts so they align with hpos/vpos
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_de    <= 1'b1;
    end else begin
      r_hsync <= !(w_hnxt >= HS_LO && w_hnxt <= HS_HI);
      r_vsync <= !(w_vnxt >= VS_LO && w_vnxt <= VS_HI);
      r_de    <= (w_hnxt < H_VIS) && (w_vnxt < V_VIS);
    end
  end

`ifdef HVSYNC_FRAME_PULSE_EN
  logic r_fs;

  // next state is (0,0) on reset or when both axes wrap together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fs <= 1'b1;
    end else begin
      r_fs <= w_vwrap;
    end
  end

  // held low while reset is applied, so the post-release pulse is clean
  assign frame_start = r_fs && rst_n;
`else
  logic w_unused;
  assign w_unused = w_vwrap;
`endif

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign display_on = r_de;
  assign hpos       = w_hcnt;
  assign vpos       = w_vcnt;

endmodule

// File: tb/tb_vga_hvsync_gen.sv
// Scoreboard bench for vga_hvsync_gen: per-cycle model queue,
// hand-computed directed vectors and whole-frame pulse counts.
module tb_vga_hvsync_gen;

  logic       clk;
  logic       rst_n;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;
`ifdef HVSYNC_FRAME_PULSE_EN
  logic       frame_start;
`endif

  vga_hvsync_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef HVSYNC_FRAME_PULSE_EN
    .frame_start(frame_start),
`endif
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int seg;
    int n;
    int h;
    int v;
    bit hs;
    bit vs;
    bit de;
    bit fs;
  } exp_t;

  exp_t sb[$];
  exp_t dv[$];

  int n_vec = 0;
  int n_err = 0;

  int seg = 0;
  int mn  = 0;
  int mh  = 0;
  int mv  = 0;

  function automatic int unsigned pk(int h, int v, bit hs, bit vs, bit de);
    return (h << 13) | (v << 3) | (int'(hs) << 2) | (int'(vs) << 1) | int'(de);
  endfunction

  function automatic void checkv(string name, int s, int n,
                                 int unsigned act, int unsigned req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s seg=%0d n=%0d got h=%0d v=%0d hs/vs/de=%b%b%b want h=%0d v=%0d hs/vs/de=%b%b%b",
               name, s, n, act >> 13, (act >> 3) & 1023, act[2], act[1], act[0],
               req >> 13, (req >> 3) & 1023, req[2], req[1], req[0]);
    end
  endfunction

  function automatic void checki(string name, int act, int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endfunction

  task automatic add_dv(int s, int n, int h, int v, bit hs, bit vs, bit de);
    exp_t d;
    d.seg = s; d.n = n; d.h = h; d.v = v;
    d.hs = hs; d.vs = vs; d.de = de; d.fs = 1'b0;
    dv.push_back(d);
  endtask

  // one clock: apply rst_n, advance the reference beam, queue expectation
  task automatic step(input logic rn);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      mh = 0; mv = 0; mn = 0;
    end else begin
      mn++;
      if (mh == 799) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    e.seg = seg; e.n = mn; e.h = mh; e.v = mv;
    e.hs = !(mh >= 656 && mh <= 751);
    e.vs = !(mv >= 490 && mv <= 491);
    e.de = (mh < 640) && (mv < 480);
    e.fs = (mh == 0) && (mv == 0) && rn;
    sb.push_back(e);
  endtask

  // monitor: pop expectations and compare against the sampled outputs
  initial begin
    exp_t e;
    exp_t d;
    int unsigned act;
    bit prev_hs = 1'b1;
    bit prev_vs = 1'b1;
    int hs_falls = 0;
    int vs_falls = 0;
    int vs_low = 0;
    int de_cnt = 0;
    int run = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) continue;
      e = sb.pop_front();
      act = pk(int'(hpos), int'(vpos), hsync, vsync, display_on);
      checkv("cycle", e.seg, e.n, act, pk(e.h, e.v, e.hs, e.vs, e.de));
`ifdef HVSYNC_FRAME_PULSE_EN
      checki("frame_start", int'(frame_start), int'(e.fs));
`endif
      if (dv.size() > 0 && dv[0].seg == e.seg && dv[0].n == e.n) begin
        d = dv.pop_front();
        checkv("directed", e.seg, e.n, act, pk(d.h, d.v, d.hs, d.vs, d.de));
      end
      if (e.seg == 2) begin
        if (e.n == 0) begin
          hs_falls = 0; vs_falls = 0; vs_low = 0; de_cnt = 0; run = 0;
        end else if (e.n < 420000) begin
          if (prev_hs && !hsync) hs_falls++;
          if (prev_vs && !vsync) vs_falls++;
          if (!prev_hs && hsync) begin
            checki("hsync_width", run, 96);
            run = 0;
          end
        end
        if (e.n < 420000) begin
          if (!vsync) vs_low++;
          if (display_on) de_cnt++;
          if (!hsync) run++;
        end
        if (e.n == 420000) begin
          checki("hsync_pulses", hs_falls, 525);
          checki("vsync_pulses", vs_falls, 1);
          checki("vsync_low_clk", vs_low, 1600);
          checki("visible_clk", de_cnt, 307200);
        end
        prev_hs = hsync;
        prev_vs = vsync;
      end
    end
  end

  // stimulus: reset, partial frame, mid-frame reset, one full frame
  initial begin
    rst_n = 1'b0;
    add_dv(0, 0, 0, 0, 1, 1, 1);
    add_dv(1, 1, 1, 0, 1, 1, 1);
    add_dv(1, 160300, 300, 200, 1, 1, 1);
    add_dv(2, 0, 0, 0, 1, 1, 1);
    add_dv(2, 1, 1, 0, 1, 1, 1);
    add_dv(2, 639, 639, 0, 1, 1, 1);
    add_dv(2, 640, 640, 0, 1, 1, 0);
    add_dv(2, 655, 655, 0, 1, 1, 0);
    add_dv(2, 656, 656, 0, 0, 1, 0);
    add_dv(2, 751, 751, 0, 0, 1, 0);
    add_dv(2, 752, 752, 0, 1, 1, 0);
    add_dv(2, 799, 799, 0, 1, 1, 0);
    add_dv(2, 800, 0, 1, 1, 1, 1);
    add_dv(2, 384000, 0, 480, 1, 1, 0);
    add_dv(2, 391999, 799, 489, 1, 1, 0);
    add_dv(2, 392000, 0, 490, 1, 0, 0);
    add_dv(2, 392656, 656, 490, 0, 0, 0);
    add_dv(2, 393599, 799, 491, 1, 0, 0);
    add_dv(2, 393600, 0, 492, 1, 1, 0);
    add_dv(2, 419999, 799, 524, 1, 1, 0);
    add_dv(2, 420000, 0, 0, 1, 1, 1);
    add_dv(2, 420001, 1, 0, 1, 1, 1);

    seg = 0;
    repeat (3) step(1'b0);
    seg = 1;
    repeat (160300) step(1'b1);
    seg = 2;
    step(1'b0);
    repeat (420005) step(1'b1);

    @(negedge clk);
    @(negedge clk);
    checki("scoreboard_drained", sb.size(), 0);
    checki("directed_all_hit", dv.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
